// File: rtl/gram_matrix_sequencer.sv
// Gram matrix G = A x A^T for a 4x4 unsigned matrix, using one shared
// multiply-accumulate unit sequenced over all 16 elements, row-major output.
module gram_matrix_sequencer #(
    parameter int DW   = 8,
    parameter int ACCW = 2*DW+2
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   c,
    input  logic [DW-1:0]   d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic [1:0]      out_row,
    output logic [1:0]      out_col,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        MAC     = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        row_cnt_q, row_cnt_d;
    logic [1:0]        i_q, i_d;
    logic [1:0]        j_q, j_d;
    logic [1:0]        k_q, k_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [ACCW-1:0]   out_data_q, out_data_d;
    logic [DW-1:0]     rows_q [4][4];

    logic              load_fire;
    logic [2*DW-1:0]   prod;
    logic [ACCW-1:0]   sum;

    // Both operands zero-extended so the product keeps its full 2*DW width.
    assign prod = {{DW{1'b0}}, rows_q[i_q][k_q]} * {{DW{1'b0}}, rows_q[j_q][k_q]};
    assign sum  = acc_q + {{(ACCW-2*DW){1'b0}}, prod};

    assign out_data = out_data_q;
    assign out_row  = i_q;
    assign out_col  = j_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_fire  = 1'b0;

        case (state_q)
            LOAD: begin
                in_ready  = Reset;
                busy      = (row_cnt_q != 2'd0);
                load_fire = in_valid && Reset;
                if (load_fire) begin
                    row_cnt_d = row_cnt_q + 2'd1;
                    if (row_cnt_q == 2'd3) begin
                        state_d = MAC;
                        i_d     = 2'd0;
                        j_d     = 2'd0;
                        k_d     = 2'd0;
                        acc_d   = '0;
                    end
                end
            end
            MAC: begin
                busy = 1'b1;
                if (k_q == 2'd3) begin
                    out_data_d = sum;
                    acc_d      = '0;
                    k_d        = 2'd0;
                    state_d    = PRESENT;
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 2'd1;
                end
            end
            PRESENT: begin
                busy      = 1'b1;
                out_valid = Reset;
                if (out_ready) begin
                    k_d   = 2'd0;
                    acc_d = '0;
                    if (i_q == 2'd3 && j_q == 2'd3) begin
                        done      = Reset;
                        state_d   = LOAD;
                        row_cnt_d = 2'd0;
                        i_d       = 2'd0;
                        j_d       = 2'd0;
                    end else begin
                        state_d = MAC;
                        j_d     = j_q + 2'd1;
                        if (j_q == 2'd3) i_d = i_q + 2'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= LOAD;
            row_cnt_q  <= 2'd0;
            i_q        <= 2'd0;
            j_q        <= 2'd0;
            k_q        <= 2'd0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    // NOTE: the row buffer is not reset; every entry is rewritten before MAC reads it.
    always_ff @(posedge Clock) begin
        if (load_fire) begin
            rows_q[row_cnt_q][0] <= a;
            rows_q[row_cnt_q][1] <= b;
            rows_q[row_cnt_q][2] <= c;
            rows_q[row_cnt_q][3] <= d;
        end
    end

endmodule

// File: tb/tb_gram_matrix_sequencer.sv
// Randomized self-checking bench for gram_matrix_sequencer against a plain
// arithmetic Gram-matrix model.
module tb_gram_matrix_sequencer;

    localparam int DW   = 8;
    localparam int ACCW = 2*DW+2;

    logic            Clock = 1'b0;
    logic            Reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   a, b, c, d;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic [1:0]      out_row, out_col;
    logic            busy;
    logic            done;

    int n_total = 0;
    int n_pass  = 0;

    always #5 Clock = ~Clock;

    gram_matrix_sequencer #(.DW(DW), .ACCW(ACCW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: G[i][j] = sum over k of A[i][k]*A[j][k].
    function automatic int gram(input int m [4][4], input int i, input int j);
        int s = 0;
        for (int k = 0; k < 4; k++) s += m[i][k] * m[j][k];
        return s;
    endfunction

    task automatic drive_noise();
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        d = 8'($urandom);
    endtask

    task automatic send_matrix(input int m [4][4], input bit gaps);
        for (int r = 0; r < 4; r++) begin
            int g;
            g = gaps ? $urandom_range(0, 2) : 0;
            for (int t = 0; t < g; t++) begin
                in_valid = 1'b0;
                drive_noise();
                #1;
                check("stall_busy", busy, (r != 0));
                @(posedge Clock); #1;
            end
            in_valid = 1'b1;
            a = 8'(m[r][0]);
            b = 8'(m[r][1]);
            c = 8'(m[r][2]);
            d = 8'(m[r][3]);
            #1;
            check("load_in_ready", in_ready, 1);
            @(posedge Clock); #1;
        end
    endtask

    // mode: 0 = out_ready high, 1 = random out_ready, 2 = stall element (1,2) for 7 cycles.
    task automatic collect(input int m [4][4], input int mode, input bit noise,
                           input bit chk_lat, input int reset_at);
        int idx = 0;
        int cyc = 0;
        int bp_cnt = 0;
        bit seen = 0;
        bit pend = 0;
        while (idx < 16 && cyc < 2000) begin
            if (reset_at >= 0 && idx == reset_at && !out_valid) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                Reset     = 1'b0;
                @(posedge Clock); #1;
                Reset = 1'b1;
                #1;
                check("rst_mid_out_valid", out_valid, 0);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_in_ready", in_ready, 1);
                check("rst_mid_done", done, 0);
                return;
            end
            in_valid = noise;
            if (noise) drive_noise();
            case (mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    out_ready = !(idx == 6 && out_valid && bp_cnt < 7);
                    if (!out_ready) bp_cnt++;
                end
                default: out_ready = 1'b1;
            endcase
            #1;
            if (pend) check("hold_valid", out_valid, 1);
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            if (out_valid) begin
                if (chk_lat && !seen) check("first_latency", cyc, 4);
                seen = 1;
                check("out_data", out_data, gram(m, idx / 4, idx % 4));
                check("out_row", out_row, idx / 4);
                check("out_col", out_col, idx % 4);
            end
            check("done", done, (out_valid && out_ready && idx == 15));
            pend = out_valid && !out_ready;
            if (out_valid && out_ready) idx++;
            @(posedge Clock); #1;
            cyc++;
        end
        if (idx < 16) check("timeout_elements", idx, 16);
        in_valid = 1'b0;
        #1;
        check("end_busy", busy, 0);
        check("end_out_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
        check("end_done", done, 0);
    endtask

    initial begin
        int m [4][4];

        // Reset held with in_valid asserted: nothing may be accepted or presented.
        Reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        drive_noise();
        for (int t = 0; t < 3; t++) begin
            @(posedge Clock); #1;
            drive_noise();
            #1;
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_done", done, 0);
        end
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        check("rst_busy", busy, 0);
        Reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge Clock); #1;

        // Basic product with known stream 30,2,6,10, 2,1,0,1, 6,0,5,3, 10,1,3,4.
        m = '{'{1, 2, 3, 4}, '{0, 1, 0, 0}, '{2, 0, 0, 1}, '{1, 1, 1, 1}};
        send_matrix(m, 0);
        collect(m, 0, 0, 1, -1);

        // Full-scale elements: every output 260100.
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = 255;
        send_matrix(m, 0);
        collect(m, 0, 0, 1, -1);

        // Backpressure on element (1,2).
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = $urandom_range(0, 255);
        send_matrix(m, 0);
        collect(m, 2, 0, 1, -1);

        // Input gaps during load, in_valid noise during MAC/PRESENT, random out_ready.
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = $urandom_range(0, 255);
        send_matrix(m, 1);
        collect(m, 1, 1, 0, -1);

        // Reset while computing element (2,1), then identity matrix.
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = $urandom_range(0, 255);
        send_matrix(m, 0);
        collect(m, 0, 0, 0, 9);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = (i == j) ? 1 : 0;
        send_matrix(m, 0);
        collect(m, 0, 0, 1, -1);

        // Random soak.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = $urandom_range(0, 255);
            send_matrix(m, 1);
            collect(m, 1, (n % 2) == 1, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
